// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: HASTI (AHB-Lite) data-memory slave behind the dmem arbiter.
// Address phase is registered into data-phase registers; a small FSM inserts
// WAIT_STATES wait cycles on legal transfers and a two-cycle ERROR response on
// illegal ones. Memory is split into four byte-lane arrays so partial writes
// only touch their enabled lanes.
module vscale_dmem_responder #(
   parameter int NUM_WORDS   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);

   localparam int         IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   state_t             state_reg, state_next;
   logic [3:0]         wcnt_reg, wcnt_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [1:0]         lane_reg, lane_next;
   logic [2:0]         size_reg, size_next;
   logic               write_reg, write_next;
   logic               legal_reg, legal_next;
   logic               hready_reg;
   logic               hresp_reg;

   logic [31:0]        word_index;
   logic               addr_legal;
   logic [3:0]         byte_en;
   logic               commit;
   logic [31:0]        rd_word;

   // Burst, lock and protection attributes carry no meaning for this memory.
   logic               unused_inputs;
   assign unused_inputs = ^{hburst, hmastlock, hprot};

   // Legality of the transfer currently presented in the address phase.
   always_comb begin
      word_index = {2'b00, haddr[31:2]};
      addr_legal = 1'b1;
      if (hsize > 3'd2)                              addr_legal = 1'b0;
      if ((hsize == 3'd1) && haddr[0])               addr_legal = 1'b0;
      if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))  addr_legal = 1'b0;
      if (word_index >= 32'(NUM_WORDS))              addr_legal = 1'b0;
   end

   // Next-state logic; IDLE, DATA and ERR2 all have hready=1 and accept a new address.
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      idx_next   = idx_reg;
      lane_next  = lane_reg;
      size_next  = size_reg;
      write_next = write_reg;
      legal_next = legal_reg;
      case (state_reg)
         S_WAIT: begin
            wcnt_next = wcnt_reg - 4'd1;
            if (wcnt_reg == 4'd1) state_next = S_DATA;
         end
         S_ERR1: state_next = S_ERR2;
         default: begin
            if (htrans[1]) begin
               idx_next   = haddr[IDX_W+1:2];
               lane_next  = haddr[1:0];
               size_next  = hsize;
               write_next = hwrite;
               legal_next = addr_legal;
               if (!addr_legal) begin
                  state_next = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_next = S_WAIT;
                  wcnt_next  = WAIT_INIT;
               end else begin
                  state_next = S_DATA;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
      endcase
   end

   // State, data-phase registers and registered bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         wcnt_reg   <= 4'd0;
         idx_reg    <= '0;
         lane_reg   <= 2'd0;
         size_reg   <= 3'd0;
         write_reg  <= 1'b0;
         legal_reg  <= 1'b0;
         hready_reg <= 1'b1;
         hresp_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         wcnt_reg   <= wcnt_next;
         idx_reg    <= idx_next;
         lane_reg   <= lane_next;
         size_reg   <= size_next;
         write_reg  <= write_next;
         legal_reg  <= legal_next;
         hready_reg <= (state_next != S_WAIT) && (state_next != S_ERR1);
         hresp_reg  <= (state_next == S_ERR1) || (state_next == S_ERR2);
      end
   end

   // Byte-lane enables from the registered size and low address bits.
   always_comb begin
      byte_en = 4'b0000;
      case (size_reg)
         3'd0:    byte_en = 4'b0001 << lane_reg;
         3'd1:    byte_en = lane_reg[1] ? 4'b1100 : 4'b0011;
         3'd2:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   // A write lands at the edge that ends its DATA cycle, unless reset abandons it.
   assign commit = (state_reg == S_DATA) && write_reg && legal_reg && !reset;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [NUM_WORDS];

         // Per-lane write port.
         always_ff @(posedge clk) begin
            if (commit && byte_en[gi]) mem[idx_reg] <= hwdata[gi*8 +: 8];
         end

         assign rd_word[gi*8 +: 8] = mem[idx_reg];
      end
   endgenerate

   // Read data is only driven during a DATA cycle.
   always_comb begin
      hrdata = (state_reg == S_DATA) ? rd_word : 32'd0;
   end

   assign hready = hready_reg;
   assign hresp  = hresp_reg;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 2 and 3 wait states)
// share the address/data bus; only the selected one sees active htrans.
// The driver pushes the expected response per transfer; a negedge monitor
// pops and compares when the selected instance completes a data phase.
module tb_vscale_dmem_responder;

   localparam int NW = 64;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] haddr, hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [2:0]  hburst = 3'd0;
   logic        hmastlock = 1'b0;
   logic [3:0]  hprot = 4'd0;
   int          sel;

   logic [1:0]  htrans0, htrans1, htrans2;
   logic [31:0] hrdata0, hrdata1, hrdata2;
   logic        hready0, hready1, hready2;
   logic        hresp0, hresp1, hresp2;

   assign htrans0 = (sel == 0) ? htrans : 2'd0;
   assign htrans1 = (sel == 1) ? htrans : 2'd0;
   assign htrans2 = (sel == 2) ? htrans : 2'd0;

   vscale_dmem_responder #(.NUM_WORDS(NW), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans0),
      .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0));

   vscale_dmem_responder #(.NUM_WORDS(NW), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans1),
      .hwdata(hwdata), .hrdata(hrdata1), .hready(hready1), .hresp(hresp1));

   vscale_dmem_responder #(.NUM_WORDS(NW), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans2),
      .hwdata(hwdata), .hrdata(hrdata2), .hready(hready2), .hresp(hresp2));

   logic [31:0] cur_hrdata;
   logic        cur_hready, cur_hresp;
   logic [1:0]  cur_htrans;

   always_comb begin
      cur_hrdata = hrdata0; cur_hready = hready0; cur_hresp = hresp0; cur_htrans = htrans0;
      case (sel)
         1: begin cur_hrdata = hrdata1; cur_hready = hready1; cur_hresp = hresp1; cur_htrans = htrans1; end
         2: begin cur_hrdata = hrdata2; cur_hready = hready2; cur_hresp = hresp2; cur_htrans = htrans2; end
         default: ;
      endcase
   end

   typedef struct {
      logic        resp;
      logic [31:0] data;
      bit          check_data;
      int          waits;
      int          tag;
   } exp_t;

   exp_t sb[$];
   exp_t cur_exp;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   int   outstanding = 0;
   int   waits = 0;
   int   tag_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: wait-cycle and completion checks on the selected instance.
   always @(negedge clk) begin
      if (mon_en) begin
         if (outstanding != 0) begin
            if (!cur_hready) begin
               waits++;
               check("wait_hresp", {31'd0, cur_hresp}, {31'd0, (sb.size() != 0) ? sb[0].resp : 1'b0});
            end else begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_completion: got completion expected none");
               end else begin
                  cur_exp = sb.pop_front();
                  check("hresp", {31'd0, cur_hresp}, {31'd0, cur_exp.resp});
                  check("wait_cycles", 32'(waits), 32'(cur_exp.waits));
                  if (cur_exp.check_data) check("hrdata", cur_hrdata, cur_exp.data);
                  $display("txn %0d dut%0d resp=%0d hrdata=0x%08h waits=%0d",
                           cur_exp.tag, sel, cur_hresp, cur_hrdata, waits);
               end
               outstanding = 0;
               waits = 0;
            end
         end else begin
            check("idle_hready", {31'd0, cur_hready}, 32'd1);
            check("idle_hresp", {31'd0, cur_hresp}, 32'd0);
            check("idle_hrdata", cur_hrdata, 32'd0);
         end
         if (reset) begin
            outstanding = 0;
            waits = 0;
         end else if (cur_hready && cur_htrans[1]) begin
            outstanding = 1;
         end
      end
   end

   // Drive one address phase; returns just after the accepting edge with hwdata set.
   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input bit push, input logic rsp,
                        input logic [31:0] d, input bit chk, input int nw);
      int guard = 0;
      exp_t e;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      htrans = 2'b10;
      while (!cur_hready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: got hready=0 for %0d cycles expected 1", guard);
      end
      if (push) begin
         e.resp = rsp; e.data = d; e.check_data = chk; e.waits = nw; e.tag = tag_cnt;
         tag_cnt++;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      hwdata = wd;
      htrans = 2'b00;
   endtask

   task automatic drain();
      int guard = 0;
      htrans = 2'b00;
      while ((outstanding != 0 || !cur_hready) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got busy for %0d cycles expected idle", guard);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; haddr = 32'd0; hwdata = 32'd0; hwrite = 1'b0;
      hsize = 3'd2; htrans = 2'b00; sel = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_hready0", {31'd0, hready0}, 32'd1);
      check("rst_hresp0",  {31'd0, hresp0},  32'd0);
      check("rst_hrdata0", hrdata0, 32'd0);
      check("rst_hready2", {31'd0, hready2}, 32'd1);
      check("rst_hrdata2", hrdata2, 32'd0);
      mon_en = 1'b1;

      // Zero wait states: write then read back-to-back, byte/halfword merges.
      issue(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'h0, 0, 0);
      issue(32'h10, 1'b0, 3'd2, 32'h0,       1, 1'b0, 32'hDEADBEEF, 1, 0);
      issue(32'h12, 1'b1, 3'd0, 32'h00AA0000, 1, 1'b0, 32'h0, 0, 0);
      issue(32'h10, 1'b1, 3'd1, 32'h00001234, 1, 1'b0, 32'h0, 0, 0);
      issue(32'h10, 1'b0, 3'd2, 32'h0,       1, 1'b0, 32'hDEAA1234, 1, 0);
      // Illegal transfers: misaligned word write, out of range, bad size, odd halfword.
      issue(32'h11, 1'b1, 3'd2, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 1, 1);
      issue(32'h10, 1'b0, 3'd2, 32'h0,       1, 1'b0, 32'hDEAA1234, 1, 0);
      issue(32'(NW*4), 1'b0, 3'd2, 32'h0,    1, 1'b1, 32'h0, 1, 1);
      issue(32'h10, 1'b0, 3'd3, 32'h0,       1, 1'b1, 32'h0, 1, 1);
      issue(32'h11, 1'b1, 3'd1, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 1, 1);
      issue(32'h10, 1'b0, 3'd2, 32'h0,       1, 1'b0, 32'hDEAA1234, 1, 0);
      drain();

      // Two wait states: distractor address during waits must not be captured.
      sel = 1;
      issue(32'h10, 1'b1, 3'd2, 32'hCAFEF00D, 1, 1'b0, 32'h0, 0, 2);
      issue(32'h10, 1'b0, 3'd2, 32'h0,        1, 1'b0, 32'hCAFEF00D, 1, 2);
      haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hwdata = 32'h12345678;
      @(posedge clk); #1;
      @(posedge clk); #1;
      htrans = 2'b00;
      drain();
      issue(32'h13, 1'b1, 3'd2, 32'h0BAD0BAD, 1, 1'b1, 32'h0, 1, 1);
      issue(32'h10, 1'b0, 3'd2, 32'h0,        1, 1'b0, 32'hCAFEF00D, 1, 2);
      drain();

      // Three wait states: reset during the second wait cycle abandons the write.
      sel = 2;
      issue(32'h20, 1'b1, 3'd2, 32'h0BADF00D, 1, 1'b0, 32'h0, 0, 3);
      drain();
      issue(32'h20, 1'b1, 3'd2, 32'h55555555, 0, 1'b0, 32'h0, 0, 3);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("post_reset_hready", {31'd0, hready2}, 32'd1);
      check("post_reset_hresp",  {31'd0, hresp2},  32'd0);
      issue(32'h20, 1'b0, 3'd2, 32'h0,        1, 1'b0, 32'h0BADF00D, 1, 3);
      drain();

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
